// File: rtl/pipe_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sequencer_pkg
// Description : Shared definitions for the pipeline sequencer. Holds the
//               sequencer state encoding, the default drain length and the
//               hard-wired zero register number.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_sequencer_pkg;

  // Sequencer states. HALT is only left through a resume pulse or reset.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10
  } seq_state_t;

  // Cycles needed for the instructions ahead of a syscall to leave EX/MEM/WB.
  localparam int DRAIN_CYCLES_DEFAULT = 3;

  // Register $zero is hard-wired, so a load targeting it never creates a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : pipe_sequencer_pkg
`default_nettype wire

// File: rtl/pipe_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all ones instead of wrapping.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset, clears the count
//               inc   - count one event this cycle
//               clear - synchronous clear, wins over inc
//               count - current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sequencer
// Description : Pipeline sequencing for the 5-stage MIPS core. Detects
//               load-use hazards, applies branch/jump redirects, and runs the
//               syscall drain/halt/resume sequence. Counts stall cycles and
//               redirect events in saturating counters.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               id_rs/id_rt/id_use_rs/_rt  - source operands of the ID instr
//               id_syscall                 - ID instruction is a syscall
//               ex_rd, ex_load             - destination/load flag of EX instr
//               ex_redirect                - taken branch/jump resolved in EX
//               resume                     - pulse releasing HALT
//               pc_en, ifid_en             - PC / IF/ID load enables
//               ifid_flush, idex_flush     - insert NOP / bubble
//               halted                     - registered HALT indication
//               stall_cnt, flush_cnt       - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sequencer
  import pipe_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_syscall,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_redirect,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int          DW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  seq_state_t    state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          load_use;
  logic          stall_inc;
  logic          flush_inc;

  assign load_use = ex_load && (ex_rd != REG_ZERO) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    // While reset is held the pipeline free-runs regardless of the inputs.
    if (rst_n) begin
      case (state)
        ST_RUN: begin
          if (ex_redirect) begin
            // ID and IF hold wrong-path instructions, so their hazards and
            // syscalls are discarded along with them.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else if (id_syscall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_nxt  = ST_DRAIN;
            drain_nxt  = DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          if (drain_cnt == '0) begin
            state_nxt = ST_HALT;
          end else begin
            drain_nxt = drain_cnt - DW'(1);
          end
        end
        ST_HALT: begin
          idex_flush = 1'b1;
          if (resume) begin
            // The syscall retires as a bubble while the next instruction
            // moves into ID.
            state_nxt = ST_RUN;
          end else begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
          end
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      halted    <= (state_nxt == ST_HALT);
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule : pipe_sequencer
`default_nettype wire
